// File: rtl/key_expand_seq_if.sv
// Round-key handshake bundle between the AES-128 key-expansion engine and its
// driver/consumer. The engine uses the slave modport.
interface key_expand_seq_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_round, rk_out, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_round, rk_out, done
    );
endinterface

// File: rtl/key_expand_seq.sv
// Sequential AES-128 key expansion: emits round keys 0..NR over valid/ready.
// Define KEYEXP_PARALLEL_SBOX_EN for four S-boxes and a single-cycle SUB phase.
module sub_tableforkey (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    // Ascending range so byte n of the table is SBOX[8n +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[{addr, 3'b000} +: 8];
endmodule

module key_expand_seq #(
    parameter int unsigned NR = 10
) (
    input logic             clk,
    input logic             rst_n,
    key_expand_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OUT  = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_MIX  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  temp_q, temp_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  rot_w3, t_word, nw0, nw1, nw2, nw3;
    logic         handshake;

    assign rot_w3 = {key_q[23:0], key_q[31:24]};

`ifdef KEYEXP_PARALLEL_SBOX_EN
    logic [31:0] sub_word;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sub_tableforkey u_sbox (
            .addr (rot_w3[8*i +: 8]),
            .dout (sub_word[8*i +: 8])
        );
    end
`else
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] sbox_in, sbox_out;

    always_comb begin
        case (cnt_q)
            2'd0:    sbox_in = rot_w3[31:24];
            2'd1:    sbox_in = rot_w3[23:16];
            2'd2:    sbox_in = rot_w3[15:8];
            default: sbox_in = rot_w3[7:0];
        endcase
    end

    sub_tableforkey u_sbox (
        .addr (sbox_in),
        .dout (sbox_out)
    );
`endif

    assign t_word = temp_q ^ {rcon_q, 24'h0};
    assign nw0    = key_q[127:96] ^ t_word;
    assign nw1    = key_q[95:64] ^ nw0;
    assign nw2    = key_q[63:32] ^ nw1;
    assign nw3    = key_q[31:0] ^ nw2;

    assign handshake = (state_q == ST_OUT) && bus.rk_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        temp_d  = temp_q;
        rcon_d  = rcon_q;
        round_d = round_q;
`ifndef KEYEXP_PARALLEL_SBOX_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    round_d = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (handshake) begin
                    if (round_q == 4'(NR)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SUB;
`ifndef KEYEXP_PARALLEL_SBOX_EN
                        cnt_d   = 2'd0;
`endif
                    end
                end
            end
            ST_SUB: begin
`ifdef KEYEXP_PARALLEL_SBOX_EN
                temp_d  = sub_word;
                state_d = ST_MIX;
`else
                case (cnt_q)
                    2'd0:    temp_d[31:24] = sbox_out;
                    2'd1:    temp_d[23:16] = sbox_out;
                    2'd2:    temp_d[15:8]  = sbox_out;
                    default: temp_d[7:0]   = sbox_out;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_MIX;
`endif
            end
            ST_MIX: begin
                key_d   = {nw0, nw1, nw2, nw3};
                round_d = round_q + 4'd1;
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                state_d = ST_OUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            temp_q  <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
`ifndef KEYEXP_PARALLEL_SBOX_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            temp_q  <= temp_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
`ifndef KEYEXP_PARALLEL_SBOX_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.rk_valid = (state_q == ST_OUT);
    assign bus.rk_round = round_q;
    assign bus.rk_out   = key_q;
    assign bus.done     = handshake && (round_q == 4'(NR));
endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq: golden FIPS-197 vectors plus a
// standalone key-schedule model with its own GF(2^8) S-box.
`timescale 1ns/1ps
module tb_key_expand_seq;
`ifdef KEYEXP_PARALLEL_SBOX_EN
    localparam int PER = 3;
`else
    localparam int PER = 6;
`endif
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    typedef struct {
        int           which;  // 0: FIPS key run, 1: all-zero key run
        int           round;
        logic [127:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [127:0] got      [0:10];
    logic [127:0] fips_got [0:10];
    logic [127:0] zero_got [0:10];
    logic [127:0] model_rk [0:10];
    vec_t         vecs     [0:6];

    key_expand_seq_if bus ();

    key_expand_seq #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int x = 1; x < 256; x++)
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one expansion; optionally stalls one round and pokes start while busy.
    task automatic run_exp(input logic [127:0] key, input int stall_round, input int stall_len,
                           input bit noise);
        int t = 0;
        int idx = 0;
        int stalled = 0;
        int exp_t;
        bit fin = 1'b0;
        compute_model(key);
        @(negedge clk);
        check("idle_busy", 128'(bus.busy), 128'd0);
        check("idle_valid", 128'(bus.rk_valid), 128'd0);
        bus.start    = 1'b1;
        bus.key_in   = key;
        bus.rk_ready = 1'b1;
        @(negedge clk);
        while (!fin && t < 400) begin
            bus.start = 1'b0;
            if (bus.rk_valid && idx == stall_round && stalled < stall_len) begin
                bus.rk_ready = 1'b0;
                stalled++;
            end else begin
                bus.rk_ready = 1'b1;
            end
            #1;
            check("busy", 128'(bus.busy), 128'd1);
            if (bus.rk_valid) begin
                check("rk_round", 128'(bus.rk_round), 128'(idx));
                check("rk_out", bus.rk_out, model_rk[idx]);
                if (bus.rk_ready) begin
                    exp_t = idx * PER + ((stall_round >= 0 && idx >= stall_round) ? stall_len : 0);
                    check("rk_time", 128'(t), 128'(exp_t));
                    check("done", 128'(bus.done), 128'(idx == 10));
                    got[idx] = bus.rk_out;
                    if (noise && (idx == 2 || idx == 5 || idx == 10)) begin
                        bus.start  = 1'b1;
                        bus.key_in = ~key;
                    end
                    if (idx == 10) fin = 1'b1;
                    idx++;
                end else begin
                    check("stall_done", 128'(bus.done), 128'd0);
                end
            end
            if (!fin) begin
                @(negedge clk);
                t++;
            end
        end
        if (!fin) check("timeout_rounds", 128'(idx), 128'd11);
        if (noise) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            @(negedge clk);
            check("start_at_done_ignored", 128'(bus.busy), 128'd0);
        end
    endtask

    initial begin
        logic [127:0] rkey;
        int           wait_cnt;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b1;
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_valid", 128'(bus.rk_valid), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_round", 128'(bus.rk_round), 128'd0);
        check("rst_out", bus.rk_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_exp(FIPS_KEY, -1, 0, 1'b0);
        fips_got = got;
        run_exp(128'd0, -1, 0, 1'b0);
        zero_got = got;

        vecs[0] = '{0, 0, FIPS_KEY};
        vecs[1] = '{0, 1, FIPS_R1};
        vecs[2] = '{0, 2, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{1, 0, 128'd0};
        vecs[5] = '{1, 1, ZERO_R1};
        vecs[6] = '{1, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int i = 0; i < 7; i++)
            check($sformatf("golden_%0d_r%0d", vecs[i].which, vecs[i].round),
                  vecs[i].which == 0 ? fips_got[vecs[i].round] : zero_got[vecs[i].round],
                  vecs[i].expected);

        // Backpressure at round 3 plus start pokes at rounds 2, 5 and at done.
        run_exp(FIPS_KEY, 3, 7, 1'b1);
        check("bp_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_exp(rkey, -1, 0, 1'b0);
        check("new_key_r0", got[0], rkey);

        // Asynchronous reset during a SUB phase.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = FIPS_KEY;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cnt  = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'd3) && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach_round3", 128'(bus.rk_round), 128'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(bus.busy), 128'd0);
        check("arst_valid", 128'(bus.rk_valid), 128'd0);
        check("arst_done", 128'(bus.done), 128'd0);
        check("arst_round", 128'(bus.rk_round), 128'd0);
        check("arst_out", bus.rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_exp(FIPS_KEY, -1, 0, 1'b0);
        check("restart_r1", got[1], FIPS_R1);

        // Back-to-back expansions separated by a single IDLE cycle.
        run_exp(128'd0, -1, 0, 1'b0);
        check("b2b_zero_r1", got[1], ZERO_R1);
        run_exp(FIPS_KEY, -1, 0, 1'b0);
        check("b2b_fips_r1", got[1], FIPS_R1);

        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_exp(rkey, int'($urandom_range(0, 10)), int'($urandom_range(1, 5)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
- Sequential AES-128 key-expansion engine.
- Sits directly upstream of the key S-box (sub_tableforkey) and drives it one byte per cycle with RotWord(w3) bytes. It consumes the substituted bytes to build SubWord.
- Emits round keys 0..10 in order to the round datapath over a valid/ready handshake.

Parameters:
- NR, 10, number of expansion rounds. Round keys produced: NR+1. Only 10 is supported for AES-128.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin expansion of key_in. Sampled only in IDLE.
- key_in  in  128  cipher key. key_in[127:96] = w0, key_in[31:0] = w3.
- busy  out  1  high from the cycle after an accepted start until the cycle after done
- rk_valid  out  1  rk_out/rk_round hold a valid round key
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready
- rk_round  out  4  round index 0..10 of rk_out
- rk_out  out  128  round key, same word order as key_in
- done  out  1  one-cycle pulse on acceptance of round 10

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - busy=0, rk_valid=0, done=0, rk_round=0, rk_out=0.
  - Rcon register=8'h01, byte counter=0.
- FSM states: IDLE, OUT, SUB, MIX.
- IDLE:
  - start=1 -> register key_in into the key register, rk_round=0, go to OUT.
  - start while not in IDLE is ignored.
- OUT:
  - rk_valid=1. rk_out and rk_round are held stable while rk_ready=0 (stall; nothing advances).
  - On handshake with rk_round==NR: done=1 for that cycle, go to IDLE. busy is 0 from the next cycle.
  - On handshake otherwise: go to SUB, byte counter=0.
- SUB (exactly 4 cycles):
  - S-box input = byte cnt of RotWord(w3) = {w3[23:0],w3[31:24]}, MSB byte first (cnt 0 -> bits 31:24).
  - S-box output is captured into temp word byte cnt at the clock edge.
  - cnt 3 -> MIX.
- MIX (1 cycle):
  - t = temp ^ {rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Register the new key; rk_round += 1.
  - rcon = xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set. Sequence 01,02,04,08,10,20,40,80,1b,36.
  - Go to OUT.
- Latency with rk_ready=1:
  - Round 0 valid 1 cycle after start.
  - Round r valid at start+1+6r (1 OUT + 4 SUB + 1 MIX per round).
  - done pulses in the round-10 OUT cycle (start+61).
- rk_valid is low in all states except OUT. rk_out retains its last value outside OUT.
- S-box: instantiated internally as one combinational sub_tableforkey. Its result is registered the same cycle; no extra pipeline.
- Reset mid-expansion: immediate return to IDLE. The partial key is discarded and rcon is reinitialised. A following start restarts from round 0.
- start in the same cycle as done (FSM leaving OUT): ignored. A new start is accepted once in IDLE.

Optional Feature:
- Macro KEYEXP_PARALLEL_SBOX_EN.
- Defined:
  - Four S-box instances; SUB lasts 1 cycle (all bytes substituted together).
  - Round r is valid at start+1+3r; done at start+31.
  - Outputs and round-key values are identical.
- Undefined: single shared S-box with 4-cycle SUB as above.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round1 = a0fafe1788542cb123a339392a6c7605.
  - round2 = f2c295f27a96b9435935807a7359f67f.
  - round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done at start+61 (start+31 with macro).
- Key all-zero:
  - round1 = 62636363626363636263636362636363.
  - round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready=0 for 7 cycles at round 3 -> rk_out/rk_round stable, rk_valid held high. Rounds 4..10 still match FIPS-197 and done is delayed by 7 cycles.
- start pulsed at rounds 2 and 5 while busy -> ignored, key sequence unchanged. start in IDLE afterwards with a new key -> round 0 equals the new key.
- rst_n low during SUB of round 4 -> busy, rk_valid, done, rk_round, rk_out = 0 asynchronously. A restart with the FIPS key reproduces the correct round1.
- Back-to-back: two expansions with different keys separated by one IDLE cycle -> both sequences correct. rcon restarts at 01 for the second (its round1 matches the golden value).
